dmem_ctrl: RTL and testbench

- Parametrised load/store bus controller; successor to the single-word data memory interface.
- Sits between the ALU/regfile datapath and the external data bus.
- Adds byte/halfword/word accesses (RV32I funct3), byte-lane selects, sign/zero extension, alignment checking, a bus timeout and an explicit busy/done/err handshake to the core.

---
 rtl/dmem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Load/store bus controller: RV32I sized accesses, lane select, extension, alignment and timeout errors.
// Latency: request to done is 2 cycles plus bus wait states. The core is stalled via busy while a request is pending.
module dmem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT     = 255,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [31:0]       req_wdata,
  input  logic              data_good,
  input  logic [31:0]       data_bus_i,
  output logic              data_read,
  output logic              data_write,
  output logic [ADDR_W-1:0] data_adr_o,
  output logic [3:0]        data_sel_o,
  output logic [31:0]       data_bus_o,
  output logic [31:0]       data_cpu_o,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_DONE, S_ERR} state_t;

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              read_q, read_d, write_q, write_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       wdat_q, wdat_d, cpu_q, cpu_d;
  logic              done_q, done_d, err_q, err_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        size_q, size_d;

  logic              size_ok, misaligned;
  logic [1:0]        eff_off;
  logic [3:0]        req_sel;
  logic [31:0]       req_rep, lane, load_val;

  always_comb begin
    if (req_read) size_ok = (req_size == 3'b000) || (req_size == 3'b001) || (req_size == 3'b010) ||
                            (req_size == 3'b100) || (req_size == 3'b101);
    else          size_ok = (req_size == 3'b000) || (req_size == 3'b001) || (req_size == 3'b010);
    misaligned = ((req_size[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_size[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    // With alignment checking off, the low bits are forced to the access's natural alignment.
    case (req_size[1:0])
      2'b00:   begin eff_off = req_addr[1:0];       req_sel = 4'b0001 << eff_off; req_rep = {4{req_wdata[7:0]}};  end
      2'b01:   begin eff_off = {req_addr[1], 1'b0}; req_sel = 4'b0011 << eff_off; req_rep = {2{req_wdata[15:0]}}; end
      default: begin eff_off = 2'b00;               req_sel = 4'b1111;            req_rep = req_wdata;            end
    endcase
  end

  always_comb begin
    lane = data_bus_i >> {off_q, 3'b000};
    case (size_q)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_val = {24'b0, lane[7:0]};
      3'b101:  load_val = {16'b0, lane[15:0]};
      default: load_val = data_bus_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    read_d  = read_q;
    write_d = write_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    cpu_d   = cpu_q;
    off_d   = off_q;
    size_d  = size_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_read || req_write) begin
          if (!size_ok || (ALIGN_CHECK && misaligned)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = req_read ? S_READ : S_WRITE;
            read_d  = req_read;
            write_d = !req_read;
            adr_d   = {req_addr[ADDR_W-1:2], 2'b00};
            sel_d   = req_sel;
            wdat_d  = req_rep;
            off_d   = eff_off;
            size_d  = req_size;
            cnt_d   = '0;
          end
        end
      end
      S_READ, S_WRITE: begin
        cnt_d = cnt_q + CW'(1);
        if (data_good) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          read_d  = 1'b0;
          write_d = 1'b0;
          if (state_q == S_READ) cpu_d = load_val;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      wdat_q  <= '0;
      cpu_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      read_q  <= read_d;
      write_q <= write_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      cpu_q   <= cpu_d;
      off_q   <= off_d;
      size_q  <= size_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign data_read  = read_q;
  assign data_write = write_q;
  assign data_adr_o = adr_q;
  assign data_sel_o = sel_q;
  assign data_bus_o = wdat_q;
  assign data_cpu_o = cpu_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = ((state_q == S_IDLE) && (req_read || req_write)) ||
                      (state_q == S_READ) || (state_q == S_WRITE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl with TIMEOUT=4: vector table of sized accesses plus reset and idle corner cases.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_read = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_size = '0;
  logic [31:0] req_wdata = '0;
  logic        data_good = 1'b0;
  logic [31:0] data_bus_i = '0;
  logic        data_read, data_write;
  logic [31:0] data_adr_o;
  logic [3:0]  data_sel_o;
  logic [31:0] data_bus_o, data_cpu_o;
  logic        busy, done, err;

  dmem_ctrl #(.ADDR_W(32), .TIMEOUT(4), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata), .data_good(data_good), .data_bus_i(data_bus_i),
    .data_read(data_read), .data_write(data_write), .data_adr_o(data_adr_o), .data_sel_o(data_sel_o),
    .data_bus_o(data_bus_o), .data_cpu_o(data_cpu_o), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd, wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata, bus;
    int          lat;          // strobe cycle on which data_good is raised; 0 = never
    bit          exp_err;
    int          exp_strobes;
    logic [31:0] exp_adr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_bo, exp_cpu;
  } vec_t;

  typedef struct { bit err; logic [31:0] cpu; } exp_t;

  exp_t exp_q[$];
  vec_t vecs[15];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rd, bit wr, logic [31:0] addr, logic [2:0] size, logic [31:0] wdata,
                              logic [31:0] bus, int lat, bit exp_err, int exp_strobes, logic [31:0] exp_adr,
                              logic [3:0] exp_sel, logic [31:0] exp_bo, logic [31:0] exp_cpu);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata; v.bus = bus; v.lat = lat;
    v.exp_err = exp_err; v.exp_strobes = exp_strobes; v.exp_adr = exp_adr; v.exp_sel = exp_sel;
    v.exp_bo = exp_bo; v.exp_cpu = exp_cpu;
    return v;
  endfunction

  task automatic do_txn(input vec_t v, input string tag);
    int   strobes = 0;
    bit   seen_end = 0;
    exp_t e;
    @(negedge clk);
    req_read = v.rd; req_write = v.wr; req_addr = v.addr; req_size = v.size; req_wdata = v.wdata;
    data_good = 1'b0;
    e.err = v.exp_err; e.cpu = v.exp_cpu;
    exp_q.push_back(e);
    for (int cyc = 0; cyc < 20 && !seen_end; cyc++) begin
      @(negedge clk);
      if (done || err) begin
        seen_end = 1;
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL %s scoreboard: got completion expected none", tag);
        end else begin
          e = exp_q.pop_front();
          check({tag, " err"}, 32'(err), 32'(e.err));
          check({tag, " done"}, 32'(done), 32'(!e.err));
          check({tag, " cpu"}, data_cpu_o, e.cpu);
        end
        check({tag, " latency"}, 32'(cyc), 32'(v.exp_strobes));
        check({tag, " strobes"}, 32'(strobes), 32'(v.exp_strobes));
        req_read = 1'b0; req_write = 1'b0; data_good = 1'b0;
      end else if (data_read || data_write) begin
        strobes++;
        if (strobes == 1) begin
          check({tag, " rd strobe"}, 32'(data_read), 32'(v.rd));
          check({tag, " wr strobe"}, 32'(data_write), 32'(!v.rd));
          check({tag, " adr"}, data_adr_o, v.exp_adr);
          check({tag, " sel"}, 32'(data_sel_o), 32'(v.exp_sel));
          check({tag, " busy"}, 32'(busy), 32'd1);
          if (!v.rd) check({tag, " bus_o"}, data_bus_o, v.exp_bo);
        end
        data_good  = (strobes == v.lat);
        data_bus_i = v.bus;
      end
    end
    if (!seen_end) begin
      n_checks++; n_errors++;
      $display("FAIL %s timeout: got no done/err expected completion", tag);
      req_read = 1'b0; req_write = 1'b0; data_good = 1'b0;
      exp_q.delete();
    end
    @(negedge clk);
    check({tag, " pulse width"}, 32'(done | err), 32'd0);
    check({tag, " idle busy"}, 32'(busy | data_read | data_write), 32'd0);
  endtask

  initial begin
    //               rd wr addr          sz      wdata         bus           lat err stb adr           sel      bus_o         cpu
    vecs[0]  = mk(1, 0, 32'h100, 3'b010, 32'h0,        32'hDEADBEEF, 3, 0, 3, 32'h100, 4'b1111, 32'h0,        32'hDEADBEEF);
    vecs[1]  = mk(1, 0, 32'h103, 3'b000, 32'h0,        32'h80123456, 1, 0, 1, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80);
    vecs[2]  = mk(1, 0, 32'h103, 3'b100, 32'h0,        32'h80123456, 2, 0, 2, 32'h100, 4'b1000, 32'h0,        32'h00000080);
    vecs[3]  = mk(0, 1, 32'h202, 3'b001, 32'h1234ABCD, 32'h0,        2, 0, 2, 32'h200, 4'b1100, 32'hABCDABCD, 32'h00000080);
    vecs[4]  = mk(1, 0, 32'h101, 3'b010, 32'h0,        32'h0,        1, 1, 0, 32'h0,   4'b0000, 32'h0,        32'h00000080);
    vecs[5]  = mk(1, 0, 32'h204, 3'b010, 32'h0,        32'h55555555, 0, 1, 4, 32'h204, 4'b1111, 32'h0,        32'h00000080);
    vecs[6]  = mk(1, 0, 32'h102, 3'b001, 32'h0,        32'h80017FFF, 4, 0, 4, 32'h100, 4'b1100, 32'h0,        32'hFFFF8001);
    vecs[7]  = mk(1, 0, 32'h100, 3'b101, 32'h0,        32'h1234F00D, 1, 0, 1, 32'h100, 4'b0011, 32'h0,        32'h0000F00D);
    vecs[8]  = mk(0, 1, 32'h001, 3'b000, 32'h000000A5, 32'h0,        1, 0, 1, 32'h0,   4'b0010, 32'hA5A5A5A5, 32'h0000F00D);
    vecs[9]  = mk(0, 1, 32'h010, 3'b010, 32'hCAFEF00D, 32'h0,        1, 0, 1, 32'h10,  4'b1111, 32'hCAFEF00D, 32'h0000F00D);
    vecs[10] = mk(1, 0, 32'h000, 3'b011, 32'h0,        32'h0,        1, 1, 0, 32'h0,   4'b0000, 32'h0,        32'h0000F00D);
    vecs[11] = mk(0, 1, 32'h000, 3'b100, 32'h0,        32'h0,        1, 1, 0, 32'h0,   4'b0000, 32'h0,        32'h0000F00D);
    vecs[12] = mk(1, 1, 32'h101, 3'b000, 32'hFFFFFFFF, 32'h00007F00, 1, 0, 1, 32'h100, 4'b0010, 32'h0,        32'h0000007F);
    vecs[13] = mk(1, 0, 32'h102, 3'b000, 32'h0,        32'h00AB0000, 2, 0, 2, 32'h100, 4'b0100, 32'h0,        32'hFFFFFFAB);
    vecs[14] = mk(1, 0, 32'h103, 3'b001, 32'h0,        32'h0,        1, 1, 0, 32'h0,   4'b0000, 32'h0,        32'hFFFFFFAB);

    repeat (3) @(negedge clk);
    check("reset outputs", {data_read, data_write, done, err, busy, data_sel_o}, 32'd0);
    check("reset adr", data_adr_o, 32'd0);
    check("reset bus_o/cpu", data_bus_o | data_cpu_o, 32'd0);
    rst = 1'b0;

    // Bus acknowledges with no request pending must be ignored.
    @(negedge clk);
    data_good = 1'b1; data_bus_i = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    check("idle data_good", {data_read, data_write, done, err, busy}, 32'd0);
    check("idle cpu", data_cpu_o, 32'd0);
    data_good = 1'b0;

    for (int i = 0; i < 15; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a store: strobes drop at once and no completion follows.
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h300; req_size = 3'b010; req_wdata = 32'h11223344;
    for (int c = 0; c < 5 && !data_write; c++) @(negedge clk);
    check("rstmid write seen", 32'(data_write), 32'd1);
    rst = 1'b1; req_write = 1'b0;
    @(negedge clk);
    check("rstmid strobes", {data_read, data_write, done, err, busy, data_sel_o}, 32'd0);
    check("rstmid adr", data_adr_o, 32'd0);
    check("rstmid bus_o/cpu", data_bus_o | data_cpu_o, 32'd0);
    rst = 1'b0;
    begin
      bit any_pulse = 0;
      repeat (3) begin
        @(negedge clk);
        if (done || err || data_write) any_pulse = 1;
      end
      check("rstmid no completion", 32'(any_pulse), 32'd0);
    end
    do_txn(mk(1, 0, 32'h300, 3'b010, 32'h0, 32'h0BADF00D, 2, 0, 2, 32'h300, 4'b1111, 32'h0, 32'h0BADF00D),
           "post-reset LW");

    if (exp_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
